// File: rtl/db_arbiter.sv
// db_arbiter: two-master round-robin arbiter for the shared physical data bus.
// Master 0 is the CPU/MMU side and master 1 is a secondary master (DMA or display fetch).
// A lock keeps a multi-transaction sequence together. The lock is bounded while the
// other master is waiting, and a watchdog aborts a transaction the slave never finishes.
`ifndef MEM_ACCESS
`define MEM_ACCESS [1:0]
`endif
`ifndef MEM_NONE
`define MEM_NONE 2'd0
`endif

module db_arbiter #(
    parameter int MAX_LOCK = 8,
    parameter int TIMEOUT  = 1024,
    parameter     TAG      = "DB_ARB"
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m0_dataOut,
    input  logic [31:0]      m1_dataOut,
    input  logic `MEM_ACCESS m0_accessType,
    input  logic `MEM_ACCESS m1_accessType,
    input  logic             m0_io,
    input  logic             m1_io,
    input  logic             m0_lock,
    input  logic             m1_lock,
    output logic [31:0]      m0_dataIn,
    output logic [31:0]      m1_dataIn,
    output logic             m0_ready,
    output logic             m1_ready,
    output logic             m0_err,
    output logic             m1_err,
    output logic [31:0]      db_addr,
    output logic [31:0]      db_dataOut,
    output logic `MEM_ACCESS db_accessType,
    output logic             db_io,
    input  logic [31:0]      db_dataIn,
    input  logic             db_ready,
    output logic [1:0]       grant
);

    localparam int LK_W = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LK_W-1:0] LOCK_LAST = LK_W'(MAX_LOCK - 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_last, w_last_nxt;      // master that completed or aborted most recently
    logic [LK_W-1:0] r_lockCnt, w_lockCnt_nxt;
    logic [WD_W-1:0] r_wdCnt, w_wdCnt_nxt;

    logic   w_req0, w_req1;
    logic   w_owned, w_sel;                   // w_sel: 1 when master 1 owns the bus
    logic   w_reqOwn, w_reqOth, w_lockOwn;
    state_t w_othState;

    assign w_req0 = (m0_accessType != `MEM_NONE);
    assign w_req1 = (m1_accessType != `MEM_NONE);

    // Read data is broadcast; only the granted master sees ready.
    assign m0_dataIn = db_dataIn;
    assign m1_dataIn = db_dataIn;
    assign grant     = {r_state == S_OWN1, r_state == S_OWN0};

    // State and counter registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;                // master 0 wins the first tie
            r_lockCnt <= '0;
            r_wdCnt   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_lockCnt <= w_lockCnt_nxt;
            r_wdCnt   <= w_wdCnt_nxt;
        end
    end

    // Arbitration, lock and watchdog next state plus bus mux and handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_lockCnt_nxt = r_lockCnt;
        w_wdCnt_nxt   = r_wdCnt;
        db_addr       = m0_addr;
        db_dataOut    = m0_dataOut;
        db_io         = m0_io;
        db_accessType = `MEM_NONE;
        m0_ready      = 1'b0;
        m1_ready      = 1'b0;
        m0_err        = 1'b0;
        m1_err        = 1'b0;

        w_owned    = (r_state == S_OWN0) || (r_state == S_OWN1);
        w_sel      = (r_state == S_OWN1);
        w_reqOwn   = w_sel ? w_req1 : w_req0;
        w_reqOth   = w_sel ? w_req0 : w_req1;
        w_lockOwn  = w_sel ? m1_lock : m0_lock;
        w_othState = w_sel ? S_OWN0 : S_OWN1;

        if (!w_owned) begin
            // Idle: the master that did not go last wins a tie.
            w_lockCnt_nxt = '0;
            w_wdCnt_nxt   = '0;
            if (w_req0 && (!w_req1 || r_last))
                w_state_nxt = S_OWN0;
            else if (w_req1)
                w_state_nxt = S_OWN1;
            else
                w_state_nxt = S_IDLE;
        end else begin
            db_addr       = w_sel ? m1_addr       : m0_addr;
            db_dataOut    = w_sel ? m1_dataOut    : m0_dataOut;
            db_io         = w_sel ? m1_io         : m0_io;
            db_accessType = w_sel ? m1_accessType : m0_accessType;

            if (db_ready) begin
                // Completion. It takes priority over a watchdog expiry on the same cycle.
                m0_ready    = !w_sel;
                m1_ready    = w_sel;
                w_last_nxt  = w_sel;
                w_wdCnt_nxt = '0;
                if (!w_lockOwn) begin
                    w_lockCnt_nxt = '0;
                    w_state_nxt   = w_reqOth ? w_othState : S_IDLE;
                end else if (w_reqOth) begin
                    if (r_lockCnt == LOCK_LAST) begin
                        w_lockCnt_nxt = '0;
                        w_state_nxt   = w_othState;
                    end else begin
                        w_lockCnt_nxt = r_lockCnt + 1'b1;
                    end
                end
            end else if (!w_reqOwn) begin
                // The owner withdrew. A held lock bridges gaps between transactions.
                if (!w_lockOwn) begin
                    w_state_nxt   = S_IDLE;
                    w_lockCnt_nxt = '0;
                    w_wdCnt_nxt   = '0;
                end
            end else if (r_wdCnt == WD_LAST) begin
                // Slave never answered. Abort without ready and ignore the lock.
                m0_err        = !w_sel;
                m1_err        = w_sel;
                w_state_nxt   = S_IDLE;
                w_last_nxt    = w_sel;
                w_lockCnt_nxt = '0;
                w_wdCnt_nxt   = '0;
            end else begin
                w_wdCnt_nxt = r_wdCnt + 1'b1;
            end
        end
    end

`ifdef DEBUG_DISPLAY
    // Trace grant changes and watchdog aborts
    always_ff @(posedge clk) begin
        if (res_n && (w_state_nxt != r_state))
            $display("%s: grant %b -> %b", TAG, grant,
                     {w_state_nxt == S_OWN1, w_state_nxt == S_OWN0});
        if (m0_err || m1_err)
            $display("%s: watchdog abort master %0d", TAG, m1_err);
    end
`endif

endmodule

// File: doc/db_arbiter.md
Name: db_arbiter

Overview:
- Two-master arbiter for the single physical data bus (DataBus.vh signalling: addr, dataOut, dataIn, accessType, ready, io).
- Master 0 is the CPU_MMU-side port; master 1 is a secondary bus master (DMA or display fetch).
- Round-robin grant with a lock input, so a master's multi-transaction sequence (e.g. sub-word read followed by write-back) is not split.
- Bounded lock hold, plus a per-transaction watchdog that aborts a transaction when the slave never asserts ready.

Parameters:
- MAX_LOCK, 8: maximum consecutive completed transactions a locked master keeps the grant while the other master is requesting.
- TIMEOUT, 1024: cycles a granted transaction may wait for db_ready before it is aborted.
- TAG, "DB_ARB": debug display prefix.

Ports:
- clk  in  1  clock.
- res_n  in  1  asynchronous active-low reset.
- m0_addr, m1_addr  in  32  physical address from master 0/1.
- m0_dataOut, m1_dataOut  in  32  write data from master 0/1.
- m0_accessType, m1_accessType  in  `MEM_ACCESS  request type; NONE means no request.
- m0_io, m1_io  in  1  io (uncachable) qualifier.
- m0_lock, m1_lock  in  1  keep grant after the current transaction.
- m0_dataIn, m1_dataIn  out  32  read data; db_dataIn broadcast to both.
- m0_ready, m1_ready  out  1  transaction complete, granted master only.
- m0_err, m1_err  out  1  one-cycle pulse on watchdog abort.
- db_addr  out  32  bus address.
- db_dataOut  out  32  bus write data.
- db_accessType  out  `MEM_ACCESS  bus request type.
- db_io  out  1  bus io qualifier.
- db_dataIn  in  32  bus read data.
- db_ready  in  1  bus transaction complete.
- grant  out  2  one-hot current owner; 00 when idle.

Behaviour:
- Reset (res_n low, asynchronous):
  - state=S_IDLE, grant=00, lastOwner=1 (so master 0 wins first tie).
  - lockCnt=0, wdCnt=0, m*_ready=0, m*_err=0, db_accessType=NONE.
- States: S_IDLE, S_OWN0, S_OWN1.
- reqN = (mN_accessType != NONE).
- Bus outputs by state:
  - S_OWNn: db_addr/db_dataOut/db_accessType/db_io are combinationally muxed from master n.
  - S_IDLE: db_accessType=NONE; db_addr, db_dataOut, db_io are don't-care.
- Grant latency: a request seen in S_IDLE moves to S_OWNn on the next edge, and the bus is driven that cycle. Minimum grant latency is 1 cycle.
- Arbitration in S_IDLE:
  - Only req0 -> S_OWN0; only req1 -> S_OWN1.
  - Both requesting -> the master that is not lastOwner wins.
- mN_ready = db_ready while in S_OWNn, else 0.
  - A transaction completes on a cycle with S_OWNn and db_ready=1.
  - On completion, lastOwner=n.
- On completion in S_OWNn:
  - mN_lock=0 -> release. Go to S_IDLE, or directly to the other master's state if it is requesting (back-to-back handover, no idle cycle). Otherwise, if master n is still requesting, it re-enters through S_IDLE arbitration.
  - mN_lock=1 and the other master is idle -> stay in S_OWNn; lockCnt unchanged.
  - mN_lock=1 and the other master is requesting -> lockCnt++. If lockCnt reaches MAX_LOCK, force release to the other master and clear lockCnt; otherwise stay.
  - Any release clears lockCnt.
- Owner withdraws (accessType=NONE) while in S_OWNn, without completion:
  - lock=0 -> release to S_IDLE.
  - lock=1 -> hold; the lock keeps the grant across gaps such as the S_SAVE_ADDR bubble.
- Watchdog:
  - wdCnt counts cycles in S_OWNn with a request active and db_ready=0.
  - Clears on completion or grant change.
  - When wdCnt = TIMEOUT-1: mN_err pulses one cycle, state -> S_IDLE, lastOwner=n, lockCnt=0. No ready is issued.
  - The lock is ignored on abort.
- Simultaneous events:
  - db_ready and watchdog expiry on the same cycle -> completion wins, no err.
  - A request that appears during the other's lock is held off; it never sees ready until granted.
- Widths: lockCnt is clog2(MAX_LOCK+1) bits; wdCnt is clog2(TIMEOUT) bits. Both saturate only via the rules above and never wrap.
- Debug: under DEBUG_DISPLAY, print grant changes and aborts with the TAG prefix.

Test Plan:
- Single master: m0 R at 0x100, db_ready 2 cycles later -> grant=01 one cycle after request; m0_ready pulses once; m0_dataIn=db_dataIn; m1_ready stays 0.
- Simultaneous first request from both after reset -> m0 served first; on its completion with lock=0 the bus hands directly to m1 with no idle cycle; then grant=00.
- Lock: m0 does R 0x200 then W 0x200 with lock=1; m1 requests throughout -> m1 is not granted until m0 completes the W with lock=0; both m0 transactions are contiguous on the bus.
- Lock starvation: m0 locked issuing continuous reads, MAX_LOCK=8, m1 requesting -> forced handover after the 8th m0 completion; m1 granted the next cycle.
- Watchdog: TIMEOUT=16, m1 W with db_ready held 0 -> m1_err pulses at the 16th owned cycle; grant=00; m1_ready never asserted. Bench also covers db_ready arriving on that exact cycle -> ready, no err.
- Reset mid-transaction: assert res_n low while in S_OWN1 -> grant=00, db_accessType=NONE, all ready/err 0 immediately; after release, m0 wins the first tie.
